rand_gen: RTL and testbench
===========================

# rand_gen

Parametrised pseudo-random number generator for the random_number design: replaces the fixed 8-entry constant lookup with a free-running Galois LFSR plus a bit-serial modulo reducer. Every accepted request produces one value in 0..MAX with a valid pulse. It feeds the display and game logic that previously indexed the constant table.

## Interface
- W, 16: LFSR width in bits (8..32).
- TAPS, 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
- SEED, 16'hACE1: reset and fallback seed; must be non-zero.
- MAX, 9999: largest output value; 1 <= MAX < 2^W.
- O, 14: output width; O >= clog2(MAX+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- seed_load  in  1  load `seed` into the LFSR this edge.
- seed  in  W  new seed; 0 is replaced by SEED.
- req  in  1  request one number; honoured only when busy=0.
- busy  out  1  high while a request is in progress (DIV or DONE).
- valid  out  1  one-cycle pulse: `out` holds a new result.
- out  out  O  last result, held until the next result.

## Operation
- LFSR advances every cycle: lfsr <= (lfsr>>1) ^ (lfsr[0] ? TAPS : 0). It never holds 0.
- seed_load overrides the advance for that edge: lfsr <= (seed==0) ? SEED : seed.
- FSM states: IDLE, DIV, DONE.
  - IDLE: busy=0. On req=1 capture sample <= current lfsr (pre-advance, pre-seed-load value), clear rem, cnt <= W-1, go to DIV.
  - DIV: restoring long division, one sample bit per cycle, MSB first: t = {rem, sample[cnt]}; rem <= (t >= MAX+1) ? t-(MAX+1) : t. When cnt==0 go to DONE, otherwise cnt decrements.
  - DONE: out <= rem[O-1:0], valid=1 for this one cycle, return to IDLE.
- rem is clog2(MAX+1)+1 bits wide. The invariant rem <= MAX holds after every step, so the result is exactly sample mod (MAX+1).
- req in DIV or DONE is ignored. Nothing is queued, and the requester must re-assert req.
- seed_load in DIV or DONE changes only the LFSR. The in-flight result uses the captured sample.
- req and seed_load in the same IDLE cycle: the sample is the old lfsr, and the seed still loads.

## Timing
- Reset values: lfsr=SEED, state=IDLE, busy=0, valid=0, out=0, rem=0, cnt=0.
- req high in cycle 0 (IDLE):
  - busy is high in cycles 1..W+1.
  - valid is high in cycle W+1 only, with the new value on out.
  - The block is IDLE in cycle W+2. With W=16, valid appears in cycle 17.
- Throughput is one result per W+2 cycles. Holding req high continuously yields a valid pulse every W+2 cycles.
- rst_n low mid-operation aborts the division immediately. No valid is emitted, and out returns to 0.
- out changes only at the edge that enters DONE. It is stable at all other times.

## Structure
- Package rand_pkg holds:
  - the state enum {IDLE, DIV, DONE};
  - default constants RAND_W=16, RAND_TAPS=16'hB400, RAND_SEED=16'hACE1, RAND_MAX=9999.
- Sub-module lfsr_galois:
  - parameters W, TAPS, SEED;
  - ports clk, rst_n, load, load_val, state;
  - contains the zero-seed substitution.
- The FSM and divider stay in rand_gen.

## Test plan
- Reset release, then req in the first cycle: sample 0xACE1=44257. Expect valid in cycle 17, out=4257, busy high in cycles 1..17.
- seed_load seed=0x2710, then req the next cycle: out=0. Repeat with seed 0x270F: out=9999. This checks the modulo boundaries.
- seed_load seed=0: next-cycle lfsr=0xACE1. Free-run 1000 cycles and check lfsr never equals 0 and matches the reference model, e.g. 0xACE1 -> 0xE270.
- req pulsed again in cycles 5 and 17 of a transaction: ignored, exactly one valid. A req in cycle 18 is accepted.
- seed_load in cycle 8 of a transaction: the result still equals the originally captured sample mod 10000, and the LFSR shows the new seed.
- rst_n asserted in cycle 10 of a transaction: busy, valid and out go to 0 asynchronously, with no valid pulse afterwards. A fresh req after release gives 4257 again.

Source files
------------

// File: rtl/rand_pkg.sv
// rand_pkg: shared types and default constants for the rand_gen random
// number generator and its LFSR.
//   state_t    : divider FSM states (IDLE, DIV, DONE)
//   RAND_W     : default LFSR width
//   RAND_TAPS  : default Galois feedback mask (x^16+x^14+x^13+x^11+1)
//   RAND_SEED  : default reset / fallback seed (non-zero)
//   RAND_MAX   : default largest output value
package rand_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          RAND_W    = 16;
    localparam logic [15:0] RAND_TAPS = 16'hB400;
    localparam logic [15:0] RAND_SEED = 16'hACE1;
    localparam int          RAND_MAX  = 9999;

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: free-running right-shifting Galois LFSR.
//   clk      in  : rising-edge clock
//   rst_n    in  : asynchronous active-low reset, loads SEED
//   load     in  : load load_val instead of advancing on this edge
//   load_val in  : new seed; zero is replaced by SEED so the register
//                  can never reach the all-zero lock-up state
//   state    out : current LFSR contents
module lfsr_galois
    import rand_pkg::*;
#(
    parameter int           W    = RAND_W,
    parameter logic [W-1:0] TAPS = W'(RAND_TAPS),
    parameter logic [W-1:0] SEED = W'(RAND_SEED)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_val == '0) ? SEED : load_val;
        end else begin
            state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/rand_gen.sv
// rand_gen: pseudo-random number generator producing values in 0..MAX.
// A free-running Galois LFSR is sampled on each accepted request and the
// sample is reduced modulo MAX+1 by a bit-serial restoring divider
// (one sample bit per cycle, MSB first).
//   clk       in  : rising-edge clock
//   rst_n     in  : asynchronous active-low reset
//   seed_load in  : load seed into the LFSR on this edge
//   seed      in  : new seed (0 selects SEED)
//   req       in  : request one number; accepted only while busy=0
//   busy      out : high while a request is being processed
//   valid     out : one-cycle pulse when out carries a new result
//   out       out : last result, held until the next one
module rand_gen
    import rand_pkg::*;
#(
    parameter int           W    = RAND_W,
    parameter logic [W-1:0] TAPS = W'(RAND_TAPS),
    parameter logic [W-1:0] SEED = W'(RAND_SEED),
    parameter int           MAX  = RAND_MAX,
    parameter int           O    = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    input  logic         req,
    output logic         busy,
    output logic         valid,
    output logic [O-1:0] out
);

    // One spare bit so the shifted partial remainder never overflows.
    localparam int            RW  = $clog2(MAX + 1) + 1;
    localparam int            CW  = $clog2(W);
    localparam logic [RW-1:0] MOD = RW'(MAX + 1);

    // One restoring-division step. rem <= MAX on entry, so dropping its
    // top bit before the shift loses nothing and t <= 2*MAX+1.
    function automatic logic [RW-1:0] div_step(input logic [RW-1:0] r,
                                               input logic          b);
        logic [RW-1:0] t;
        t = {r[RW-2:0], b};
        return (t >= MOD) ? (t - MOD) : t;
    endfunction

    logic [W-1:0]  lfsr;
    logic [W-1:0]  sample;
    logic [RW-1:0] rem;
    logic [RW-1:0] rem_nxt;
    logic [CW-1:0] cnt;
    state_t        state;

    lfsr_galois #(
        .W    (W),
        .TAPS (TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (seed_load),
        .load_val (seed),
        .state    (lfsr)
    );

    assign rem_nxt = div_step(rem, sample[cnt]);

    // The result is written on the final DIV step so that out and valid
    // both change on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            out    <= '0;
            rem    <= '0;
            cnt    <= '0;
            sample <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        sample <= lfsr;
                        rem    <= '0;
                        cnt    <= CW'(W - 1);
                        busy   <= 1'b1;
                        state  <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_nxt;
                    if (cnt == '0) begin
                        out   <= O'(rem_nxt);
                        valid <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_gen.sv
// tb_rand_gen: self-checking bench for rand_gen with its default parameters.
// A reference model tracks the LFSR sequence from the update rule and
// computes expected results with the % operator.
module tb_rand_gen;

    localparam int          W    = 16;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          MAX  = 9999;
    localparam int          O    = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed = '0;
    logic          req = 1'b0;
    logic          busy;
    logic          valid;
    logic [O-1:0]  out;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [W-1:0]  m_lfsr  = SEED;

    rand_gen #(
        .W    (W),
        .TAPS (TAPS),
        .SEED (SEED),
        .MAX  (MAX),
        .O    (O)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .busy      (busy),
        .valid     (valid),
        .out       (out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_next(input logic [W-1:0] x);
        return (x >> 1) ^ (x[0] ? TAPS : 16'h0000);
    endfunction

    function automatic logic [O-1:0] model_mod(input logic [W-1:0] x);
        return O'(int'(x) % (MAX + 1));
    endfunction

    // Advance one clock and keep the LFSR model in step with the DUT.
    task automatic tick();
        @(posedge clk);
        if (!rst_n)          m_lfsr = SEED;
        else if (seed_load)  m_lfsr = (seed == '0) ? SEED : seed;
        else                 m_lfsr = model_next(m_lfsr);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid); end
        n_tests++; if (out !== '0)     begin n_fail++; $display("FAIL reset_out got=%0d exp=0", out); end
        n_tests++; if (dut.lfsr !== SEED) begin n_fail++; $display("FAIL reset_lfsr got=%h exp=%h", dut.lfsr, SEED); end
        rst_n  = 1'b1;
        m_lfsr = SEED;
    endtask

    // Request in the first cycle after reset release.
    task automatic test_first_req();
        logic [W-1:0] s;
        logic [O-1:0] prev;
        s = m_lfsr;
        prev = out;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            n_tests++; if (busy !== (c <= W + 1)) begin n_fail++; $display("FAIL first_busy c=%0d got=%b", c, busy); end
            n_tests++; if (valid !== (c == W + 1)) begin n_fail++; $display("FAIL first_valid c=%0d got=%b", c, valid); end
            if (c == W + 1) begin
                n_tests++; if (out !== model_mod(s)) begin n_fail++; $display("FAIL first_out got=%0d exp=%0d", out, model_mod(s)); end
                n_tests++; if (out !== 14'd4257) begin n_fail++; $display("FAIL first_out_const got=%0d exp=4257", out); end
                prev = out;
            end else begin
                n_tests++; if (out !== prev) begin n_fail++; $display("FAIL first_out_stable c=%0d got=%0d exp=%0d", c, out, prev); end
            end
            tick();
        end
    endtask

    task automatic test_boundaries();
        logic [W-1:0] seeds [2];
        logic [O-1:0] exps  [2];
        bit           seen;
        seeds[0] = 16'h2710; exps[0] = 14'd0;
        seeds[1] = 16'h270F; exps[1] = 14'd9999;
        for (int i = 0; i < 2; i++) begin
            seed_load = 1'b1;
            seed = seeds[i];
            tick();
            seed_load = 1'b0;
            n_tests++; if (dut.lfsr !== seeds[i]) begin n_fail++; $display("FAIL bound_load got=%h exp=%h", dut.lfsr, seeds[i]); end
            req = 1'b1;
            tick();
            req = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                if (valid) seen = 1'b1;
                else tick();
            end
            n_tests++;
            if (!seen) begin n_fail++; $display("FAIL bound_timeout got=no_valid exp=valid"); end
            else if (out !== exps[i]) begin n_fail++; $display("FAIL bound_out got=%0d exp=%0d", out, exps[i]); end
            tick();
            tick();
        end
    endtask

    task automatic test_zero_seed_freerun();
        seed_load = 1'b1;
        seed = '0;
        tick();
        seed_load = 1'b0;
        n_tests++; if (dut.lfsr !== SEED) begin n_fail++; $display("FAIL zero_seed got=%h exp=%h", dut.lfsr, SEED); end
        tick();
        n_tests++; if (dut.lfsr !== 16'hE270) begin n_fail++; $display("FAIL lfsr_step got=%h exp=e270", dut.lfsr); end
        for (int k = 0; k < 1000; k++) begin
            tick();
            n_tests++;
            if (dut.lfsr === '0 || dut.lfsr !== m_lfsr) begin
                n_fail++;
                $display("FAIL freerun k=%0d got=%h exp=%h", k, dut.lfsr, m_lfsr);
            end
        end
    endtask

    task automatic test_ignored_req();
        logic [W-1:0] s1, s2;
        int nv;
        s1 = m_lfsr;
        s2 = '0;
        nv = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 2 * (W + 2); c++) begin
            if (valid) nv++;
            if (c == W + 1) begin
                n_tests++; if (valid !== 1'b1 || out !== model_mod(s1)) begin n_fail++; $display("FAIL ign_out1 v=%b got=%0d exp=%0d", valid, out, model_mod(s1)); end
            end
            if (c == 2 * W + 3) begin
                n_tests++; if (valid !== 1'b1 || out !== model_mod(s2)) begin n_fail++; $display("FAIL ign_out2 v=%b got=%0d exp=%0d", valid, out, model_mod(s2)); end
            end
            if (c == W + 2) s2 = m_lfsr;
            req = (c == 5 || c == W + 1 || c == W + 2);
            tick();
        end
        req = 1'b0;
        n_tests++; if (nv !== 2) begin n_fail++; $display("FAIL ign_count got=%0d exp=2", nv); end
    endtask

    task automatic test_seed_mid();
        logic [W-1:0] s, ns;
        s  = m_lfsr;
        ns = W'($urandom) | 16'h0001;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            if (c == 9) begin
                n_tests++; if (dut.lfsr !== ns) begin n_fail++; $display("FAIL mid_seed_lfsr got=%h exp=%h", dut.lfsr, ns); end
            end
            if (c == W + 1) begin
                n_tests++; if (valid !== 1'b1 || out !== model_mod(s)) begin n_fail++; $display("FAIL mid_seed_out v=%b got=%0d exp=%0d", valid, out, model_mod(s)); end
            end
            seed_load = (c == 8);
            seed = ns;
            tick();
        end
        seed_load = 1'b0;
    endtask

    task automatic test_reset_mid();
        int nv;
        nv = 0;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got=%b exp=0", valid); end
        n_tests++; if (out !== '0)     begin n_fail++; $display("FAIL rmid_out got=%0d exp=0", out); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (valid) nv++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (valid) nv++;
            tick();
        end
        n_tests++; if (nv !== 0) begin n_fail++; $display("FAIL rmid_novalid got=%0d exp=0", nv); end
        // fresh start from the reset seed
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int c = 1; c <= W + 2; c++) begin
            if (c == W + 1) begin
                n_tests++; if (valid !== 1'b1 || out !== 14'd4257) begin n_fail++; $display("FAIL rmid_fresh v=%b got=%0d exp=4257", valid, out); end
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] s;
        bit seen;
        for (int i = 0; i < 20; i++) begin
            seed_load = 1'b1;
            seed = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            tick();
            seed_load = 1'b0;
            repeat ($urandom_range(0, 5)) tick();
            s = m_lfsr;
            req = 1'b1;
            tick();
            req = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 40 && !seen; k++) begin
                if (valid) seen = 1'b1;
                else tick();
            end
            n_tests++;
            if (!seen) begin n_fail++; $display("FAIL rand_timeout i=%0d got=no_valid exp=valid", i); end
            else if (out !== model_mod(s)) begin n_fail++; $display("FAIL rand_out i=%0d got=%0d exp=%0d", i, out, model_mod(s)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] q[$];
        logic [W-1:0] s;
        req = 1'b1;
        for (int c = 0; c < 5 * (W + 2); c++) begin
            if (c % (W + 2) == 0) q.push_back(m_lfsr);
            if (c > 0) begin
                n_tests++; if (valid !== (c % (W + 2) == W + 1)) begin n_fail++; $display("FAIL b2b_valid c=%0d got=%b", c, valid); end
                if (c % (W + 2) == W + 1) begin
                    s = q.pop_front();
                    n_tests++; if (out !== model_mod(s)) begin n_fail++; $display("FAIL b2b_out c=%0d got=%0d exp=%0d", c, out, model_mod(s)); end
                end
            end
            tick();
        end
        req = 1'b0;
        repeat (W + 3) tick();
    endtask

    initial begin
        test_reset();
        test_first_req();
        test_boundaries();
        test_zero_seed_freerun();
        test_ignored_req();
        test_seed_mid();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
